aging_arbiter: RTL and testbench

AGING_ARBITER -- requirements
Module: aging_arbiter

---
 rtl/aging_arbiter.sv | 124 ++++++++++++
 tb/tb_aging_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aging_arbiter.sv
// Four-requester aging arbiter: the oldest pending request wins, ties go to the lowest index.
// Define AGING_ARB_TIMEOUT_EN to limit each grant tenure to HOLD_MAX cycles.
module aging_arbiter #(
  parameter int AGE_W    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic [3:0] age_sat
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must lie in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [3:0]       gnt_next;
  logic [1:0]       owner_next;
  logic [AGE_W-1:0] age [4];
  logic [1:0]       win_idx;
  logic             win_found;
  logic [AGE_W-1:0] win_age;
  logic             tenure_end;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    win_age   = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (!win_found || age[i] > win_age)) begin
        win_idx   = 2'(i);
        win_found = 1'b1;
        win_age   = age[i];
      end
    end
  end

`ifdef AGING_ARB_TIMEOUT_EN
  logic [7:0] hold, hold_next;

  assign tenure_end = (hold == 8'(HOLD_MAX - 1));

  always_comb begin
    hold_next = '0;
    if (state == GRANT && state_next == GRANT) hold_next = hold + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) hold <= '0;
    else       hold <= hold_next;
  end
`else
  assign tenure_end = 1'b0;
`endif

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    owner_next = owner;
    unique case (state)
      IDLE: begin
        gnt_next   = '0;
        owner_next = '0;
        if (win_found) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << win_idx;
          owner_next = win_idx;
        end
      end
      GRANT: begin
        if (!req[owner] || tenure_end) begin
          state_next = IDLE;
          gnt_next   = '0;
          owner_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        owner_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      owner <= owner_next;
    end
  end

  // The current holder keeps its cleared age; anyone else waiting ages by one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || !req[i] || gnt_next[i]) age[i] <= '0;
      else if (!gnt[i])                     age[i] <= sat_inc(age[i]);
    end
  end

  assign busy = (state == GRANT);

  always_comb begin
    for (int i = 0; i < 4; i++) age_sat[i] = (age[i] == AGE_MAX);
  end

endmodule

// File: tb/tb_aging_arbiter.sv
// Directed, table-driven bench for aging_arbiter; timeout sequences run when AGING_ARB_TIMEOUT_EN is defined.
module tb_aging_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] age_sat;

  int errors = 0;
  int checks = 0;

  aging_arbiter #(.AGE_W(4), .HOLD_MAX(8)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .owner(owner), .busy(busy), .age_sat(age_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] e_gnt;
    logic [1:0] e_owner;
    logic       e_busy;
    logic [3:0] e_sat;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    reset = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  // Grants must be one-hot and a new owner never follows another without a gap.
  logic [3:0] prev_gnt = '0;
  always @(negedge clk) begin
    checks++;
    if ($countones(gnt) > 1) begin
      errors++;
      $display("FAIL onehot: got %b, expected at most one bit", gnt);
    end
    if (prev_gnt != 4'b0 && gnt != 4'b0) begin
      checks++;
      if (gnt != prev_gnt) begin
        errors++;
        $display("FAIL gap: got %b after %b, expected an idle cycle", gnt, prev_gnt);
      end
    end
    prev_gnt = gnt;
  end

  vec_t tbl [25];

  initial begin
    reset = 1'b1;
    req   = '0;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0000};
    tbl[5]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0000};
    tbl[6]  = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'b0000};
    tbl[8]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[11] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[12] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[13] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[14] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[15] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[16] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[17] = '{1'b0, 4'b0110, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[18] = '{1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1, 4'b0000};
    tbl[19] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[20] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[21] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[22] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[23] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[24] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};

    for (int v = 0; v < 25; v++) begin
      step(tbl[v].rst, tbl[v].rq);
      check($sformatf("vec%0d gnt", v),   {4'b0, gnt},     {4'b0, tbl[v].e_gnt});
      check($sformatf("vec%0d owner", v), {6'b0, owner},   {6'b0, tbl[v].e_owner});
      check($sformatf("vec%0d busy", v),  {7'b0, busy},    {7'b0, tbl[v].e_busy});
      check($sformatf("vec%0d sat", v),   {4'b0, age_sat}, {4'b0, tbl[v].e_sat});
    end

`ifdef AGING_ARB_TIMEOUT_EN
    // Single holder is cut off after exactly HOLD_MAX cycles.
    step(1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b0100);
      check($sformatf("tmo hold%0d", k), {4'b0, gnt}, 8'h04);
    end
    step(1'b0, 4'b0100);
    check("tmo drop", {4'b0, gnt}, 8'h00);
    step(1'b0, 4'b0000);

    // Two constant requesters alternate tenures with one-cycle gaps.
    step(1'b1, 4'b0000);
    begin
      logic [3:0] pat [3];
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0001;
      for (int g = 0; g < 3; g++) begin
        for (int k = 0; k < 8; k++) begin
          step(1'b0, 4'b0011);
          check($sformatf("alt g%0d c%0d", g, k), {4'b0, gnt}, {4'b0, pat[g]});
        end
        step(1'b0, 4'b0011);
        check($sformatf("alt gap%0d", g), {4'b0, gnt}, 8'h00);
      end
    end
    step(1'b0, 4'b0000);
`else
    // Long tenure by requester 0 while requester 3 waits and saturates.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    check("sat initial gnt", {4'b0, gnt}, 8'h01);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'b1001);
      check($sformatf("sat gnt c%0d", k), {4'b0, gnt}, 8'h01);
      check($sformatf("sat flag c%0d", k), {4'b0, age_sat}, (k >= 15) ? 8'h08 : 8'h00);
    end
    step(1'b0, 4'b0001);
    check("sat clear", {4'b0, age_sat}, 8'h00);
    check("sat clear gnt", {4'b0, gnt}, 8'h01);
    step(1'b0, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
